// File: rtl/valid_tag_pipeline.sv
// Purpose: valid/tag shadow pipeline for a DEPTH-stage datapath, with bubble collapse, flush and occupancy.
// Latency: DEPTH cycles from presentation to out_valid when unstalled; one token per cycle.
// Backpressure: out_ready ripples back through a combinational ready chain; STALL_EN=0 ignores it.
module valid_tag_pipeline #(
  parameter int DEPTH    = 19,
  parameter int TAG_W    = 8,
  parameter int STALL_EN = 1,
  localparam int OCC_W   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [TAG_W-1:0] in_tag,
  output logic             in_ready,
  output logic             out_valid,
  output logic [TAG_W-1:0] out_tag,
  input  logic             out_ready,
  output logic [DEPTH-1:0] stage_adv,
  output logic [OCC_W-1:0] occupancy,
  output logic             full,
  output logic             empty
);

  // With backpressure disabled the last stage always drains, ready or not.
  localparam logic FREE_RUN = (STALL_EN == 0);

  logic [DEPTH-1:0] v;
  logic [TAG_W-1:0] tag [DEPTH];
  logic [DEPTH-1:0] rdy;
  logic [DEPTH-1:0] v_src;
  logic [TAG_W-1:0] tag_src [DEPTH];
  logic             chain;
  logic             acc_in;
  logic             acc_out;
  logic [OCC_W-1:0] occ;

  // Ready chain: a stage can move if it is empty or everything in front of it can move.
  // Built with a running variable so the chain is a simple OR-accumulate from the tail.
  always_comb begin
    rdy   = '1;
    chain = 1'b1;
    if (!FREE_RUN) begin
      chain = out_ready;
      for (int k = DEPTH - 1; k >= 0; k--) begin
        chain  = chain | ~v[k];
        rdy[k] = chain;
      end
    end
  end

  // Source of each stage: stage 0 loads the input, others load their predecessor.
  always_comb begin
    v_src[0]   = in_valid;
    tag_src[0] = in_tag;
    for (int k = 1; k < DEPTH; k++) begin
      v_src[k]   = v[k-1];
      tag_src[k] = tag[k-1];
    end
  end

  assign stage_adv = rdy & {DEPTH{~flush}};
  assign in_ready  = rdy[0] & ~flush;
  assign out_valid = v[DEPTH-1];
  assign out_tag   = tag[DEPTH-1];

  // A token is counted in on acceptance and out when the last stage drains (never during flush).
  assign acc_in  = in_valid & in_ready;
  assign acc_out = v[DEPTH-1] & (out_ready | FREE_RUN) & ~flush;

  // Valid bits: flush clears every stage; otherwise each enabled stage takes its source.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      v <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (stage_adv[k]) v[k] <= v_src[k];
      end
    end
  end

  // Tags move only with a valid token; bubbles leave the old tag behind as a don't-care.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) tag[k] <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (stage_adv[k] && v_src[k]) tag[k] <= tag_src[k];
      end
    end
  end

  // Occupancy: accept and retire in the same cycle cancel; full blocks accept unless a retire frees a slot.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      occ <= '0;
    end else begin
      occ <= occ + OCC_W'(acc_in) - OCC_W'(acc_out);
    end
  end

  assign occupancy = occ;
  assign full      = (occ == OCC_W'(DEPTH));
  assign empty     = (occ == '0);

endmodule

// File: tb/tb_valid_tag_pipeline.sv
module tb_valid_tag_pipeline;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, flush;

  // d0: DEPTH=19, TAG_W=8, STALL_EN=1
  logic       iv0, ir0, ov0, or0, full0, empty0;
  logic [7:0] it0, ot0;
  logic [18:0] adv0;
  logic [4:0] occ0;
  // d1: DEPTH=19, TAG_W=8, STALL_EN=0
  logic       iv1, ir1, ov1, or1, full1, empty1;
  logic [7:0] it1, ot1;
  logic [18:0] adv1;
  logic [4:0] occ1;
  // d2: DEPTH=1, TAG_W=1, STALL_EN=1
  logic       iv2, ir2, ov2, or2, full2, empty2;
  logic [0:0] it2, ot2, adv2, occ2;

  valid_tag_pipeline #(.DEPTH(19), .TAG_W(8), .STALL_EN(1)) d0 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(iv0), .in_tag(it0), .in_ready(ir0),
    .out_valid(ov0), .out_tag(ot0), .out_ready(or0), .stage_adv(adv0),
    .occupancy(occ0), .full(full0), .empty(empty0));

  valid_tag_pipeline #(.DEPTH(19), .TAG_W(8), .STALL_EN(0)) d1 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(iv1), .in_tag(it1), .in_ready(ir1),
    .out_valid(ov1), .out_tag(ot1), .out_ready(or1), .stage_adv(adv1),
    .occupancy(occ1), .full(full1), .empty(empty1));

  valid_tag_pipeline #(.DEPTH(1), .TAG_W(1), .STALL_EN(1)) d2 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(iv2), .in_tag(it2), .in_ready(ir2),
    .out_valid(ov2), .out_tag(ot2), .out_ready(or2), .stage_adv(adv2),
    .occupancy(occ2), .full(full2), .empty(empty2));

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [0:0] q2[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  // Expected responses: every accepted token is queued in order; flush/reset kill the queue.
  always @(negedge clk) begin
    if (rst || flush) q0.delete(); else if (iv0 && ir0) q0.push_back(it0);
    if (rst || flush) q1.delete(); else if (iv1 && ir1) q1.push_back(it1);
    if (rst || flush) q2.delete(); else if (iv2 && ir2) q2.push_back(it2);
  end

  // Output monitor: every retiring token must match the oldest expected tag.
  always @(negedge clk) begin
    logic [7:0] e;
    if (!rst && !flush && ov0 && or0) begin
      if (q0.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL d0_unexpected_output: got tag 0x%0h expected no token", ot0);
      end else begin
        e = q0.pop_front();
        check("d0_sb_tag", 32'(ot0), 32'(e));
      end
    end
    if (!rst && !flush && ov1) begin
      if (q1.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL d1_unexpected_output: got tag 0x%0h expected no token", ot1);
      end else begin
        e = q1.pop_front();
        check("d1_sb_tag", 32'(ot1), 32'(e));
      end
    end
    if (!rst && !flush && ov2 && or2) begin
      if (q2.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL d2_unexpected_output: got tag 0x%0h expected no token", ot2);
      end else begin
        e = 8'(q2.pop_front());
        check("d2_sb_tag", 32'(ot2), 32'(e));
      end
    end
  end

  initial begin
    int acc;
    int peak;
    int cnt;
    logic [18:0] mv, mr;
    logic ch;

    rst = 1'b1; flush = 1'b0;
    iv0 = 0; it0 = 0; or0 = 1;
    iv1 = 0; it1 = 0; or1 = 0;
    iv2 = 0; it2 = 0; or2 = 1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_out_valid", 32'(ov0), 32'd0);
    check("rst_out_tag", 32'(ot0), 32'd0);
    check("rst_empty", 32'(empty0), 32'd1);
    check("rst_full", 32'(full0), 32'd0);
    check("rst_occ", 32'(occ0), 32'd0);
    check("rst_in_ready", 32'(ir0), 32'd1);
    next();

    // Test 1: single token, latency 19
    or0 = 1;
    for (int c = 0; c < 25; c++) begin
      iv0 = (c == 0); it0 = 8'h5A;
      @(negedge clk);
      check("t1_out_valid", 32'(ov0), 32'(c == 19));
      check("t1_occ", 32'(occ0), 32'(c >= 1 && c <= 19));
      if (c == 19) check("t1_out_tag", 32'(ot0), 32'h5A);
      next();
    end

    // Test 2: 40 back-to-back tokens
    peak = 0;
    for (int c = 0; c < 70; c++) begin
      iv0 = (c < 40); it0 = 8'(c);
      @(negedge clk);
      if (c < 40) check("t2_in_ready", 32'(ir0), 32'd1);
      check("t2_out_valid", 32'(ov0), 32'(c >= 19 && c <= 58));
      if (c >= 19 && c <= 58) check("t2_out_tag", 32'(ot0), 32'(c - 19));
      if (int'(occ0) > peak) peak = int'(occ0);
      next();
    end
    check("t2_occ_peak", 32'(peak), 32'd19);

    // Test 3: fill against a stalled sink, then drain
    or0 = 0; acc = 0;
    for (int c = 0; c < 30; c++) begin
      iv0 = 1; it0 = 8'(100 + acc);
      @(negedge clk);
      if (ir0) acc++;
      next();
    end
    iv0 = 0;
    @(negedge clk);
    check("t3_accepted", 32'(acc), 32'd19);
    check("t3_full", 32'(full0), 32'd1);
    check("t3_in_ready", 32'(ir0), 32'd0);
    check("t3_occ", 32'(occ0), 32'd19);
    check("t3_head_tag", 32'(ot0), 32'd100);
    next();
    or0 = 1;
    for (int c = 0; c < 19; c++) begin
      @(negedge clk);
      check("t3_drain_valid", 32'(ov0), 32'd1);
      check("t3_drain_occ", 32'(occ0), 32'(19 - c));
      next();
    end
    @(negedge clk);
    check("t3_empty", 32'(empty0), 32'd1);
    check("t3_out_valid", 32'(ov0), 32'd0);
    next();

    // Test 4: alternating valid/bubble against a stalled sink, with a stage_adv model
    or0 = 0; acc = 0; mv = '0;
    for (int c = 0; c < 60; c++) begin
      iv0 = (c % 2 == 0); it0 = 8'(8'h40 + acc);
      @(negedge clk);
      ch = or0;
      for (int k = 18; k >= 0; k--) begin
        ch = ch | ~mv[k];
        mr[k] = ch;
      end
      cnt = 0;
      for (int k = 0; k < 19; k++) cnt += int'(mv[k]);
      check("t4_stage_adv", 32'(adv0), 32'(mr));
      check("t4_in_ready", 32'(ir0), 32'(mr[0]));
      check("t4_occ", 32'(occ0), 32'(cnt));
      if (iv0 && mr[0]) acc++;
      for (int k = 18; k >= 1; k--) if (mr[k]) mv[k] = mv[k-1];
      if (mr[0]) mv[0] = iv0;
      next();
    end
    check("t4_accepted", 32'(acc), 32'd19);
    check("t4_full", 32'(full0), 32'd1);
    iv0 = 0; or0 = 1;
    repeat (22) next();
    @(negedge clk);
    check("t4_drained", 32'(empty0), 32'd1);
    next();

    // Test 5a: flush with 10 tokens in flight
    or0 = 0;
    for (int c = 0; c < 10; c++) begin
      iv0 = 1; it0 = 8'(8'h80 + c);
      next();
    end
    iv0 = 1; it0 = 8'hEE; flush = 1;
    @(negedge clk);
    check("t5_flush_in_ready", 32'(ir0), 32'd0);
    check("t5_preflush_occ", 32'(occ0), 32'd10);
    next();
    flush = 0; iv0 = 0;
    @(negedge clk);
    check("t5_flush_empty", 32'(empty0), 32'd1);
    check("t5_flush_out_valid", 32'(ov0), 32'd0);
    check("t5_flush_occ", 32'(occ0), 32'd0);
    next();

    // Test 5b: reset (with concurrent flush) while full and stalled
    for (int c = 0; c < 25; c++) begin
      iv0 = 1; it0 = 8'(8'hC0 + c);
      next();
    end
    @(negedge clk);
    check("t5_stall_full", 32'(full0), 32'd1);
    check("t5_stall_out_valid", 32'(ov0), 32'd1);
    next();
    rst = 1; flush = 1;
    next();
    rst = 0; flush = 0; iv0 = 0;
    @(negedge clk);
    check("t5_rst_out_valid", 32'(ov0), 32'd0);
    check("t5_rst_out_tag", 32'(ot0), 32'd0);
    check("t5_rst_empty", 32'(empty0), 32'd1);
    check("t5_rst_full", 32'(full0), 32'd0);
    check("t5_rst_occ", 32'(occ0), 32'd0);
    check("t5_rst_in_ready", 32'(ir0), 32'd1);
    next();

    // Test 6a: free-running build ignores out_ready
    or1 = 0;
    for (int c = 0; c < 50; c++) begin
      iv1 = (c < 25); it1 = 8'(200 + c);
      @(negedge clk);
      check("t6_in_ready", 32'(ir1), 32'd1);
      check("t6_out_valid", 32'(ov1), 32'(c >= 19 && c < 44));
      if (c >= 19 && c < 44) check("t6_out_tag", 32'(ot1), 32'(200 + c - 19));
      next();
    end
    @(negedge clk);
    check("t6_empty", 32'(empty1), 32'd1);
    next();

    // Test 6b: DEPTH=1 build, latency 1
    or2 = 1;
    for (int c = 0; c < 4; c++) begin
      iv2 = (c == 0); it2 = 1'b1;
      @(negedge clk);
      check("t6d1_out_valid", 32'(ov2), 32'(c == 1));
      check("t6d1_occ", 32'(occ2), 32'(c == 1));
      if (c == 1) check("t6d1_out_tag", 32'(ot2), 32'd1);
      next();
    end
    or2 = 0; iv2 = 1; it2 = 1'b0;
    @(negedge clk);
    check("t6d1_rdy_empty", 32'(ir2), 32'd1);
    next();
    it2 = 1'b1;
    @(negedge clk);
    check("t6d1_rdy_stalled", 32'(ir2), 32'd0);
    check("t6d1_full", 32'(full2), 32'd1);
    check("t6d1_held_tag", 32'(ot2), 32'd0);
    next();
    or2 = 1;
    @(negedge clk);
    check("t6d1_rdy_retire", 32'(ir2), 32'd1);
    next();
    iv2 = 0;
    @(negedge clk);
    check("t6d1_second_valid", 32'(ov2), 32'd1);
    check("t6d1_second_tag", 32'(ot2), 32'd1);
    next();
    @(negedge clk);
    check("t6d1_final_empty", 32'(empty2), 32'd1);
    next();

    // Nothing should be left outstanding
    check("q0_leftover", 32'(q0.size()), 32'd0);
    check("q1_leftover", 32'(q1.size()), 32'd0);
    check("q2_leftover", 32'(q2.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
